// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: drives select A/B/C and active-low enable G of a 3-to-8 decoder
// Ports: clk_i, rst_ni (sync, active-low), en_i (auto step), mode_i (00 up, 01 down,
// 10 ping-pong, 11 hold), step_i (single step when en_i=0), load_i/load_val_i (load position),
// out_en_i (allow G low); a_o/b_o/c_o select, g_o enable, dir_o direction, wrap_o period pulse.
module decoder_scan_sequencer #(
  parameter int TICK_DIV  = 4,
  parameter int BLANK_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] mode_i,
  input  logic       step_i,
  input  logic       load_i,
  input  logic [2:0] load_val_i,
  input  logic       out_en_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       g_o,
  output logic       dir_o,
  output logic       wrap_o
);
  logic [2:0]       pos_q, pos_d, pos_adv;
  logic             dir_q, dir_d, dir_adv;
  logic             wrap_q, wrap_d, wrap_adv;
  logic [CNT_W-1:0] cnt_q, cnt_d, blank_q, blank_d;
  logic             step_q, g_q, g_d;
  logic             tick, adv, moved, going_up, wr;
  always_comb begin
    tick     = en_i && cnt_q == CNT_W'(TICK_DIV - 1);
    adv      = tick | (step_i & ~step_q & ~en_i);
    going_up = dir_q ? pos_q == 3'd0 : pos_q != 3'd7;
    pos_adv  = pos_q;
    dir_adv  = dir_q;
    wrap_adv = 1'b0;
    moved    = 1'b1;
    case (mode_i)
      2'b00: begin
        pos_adv  = pos_q + 3'd1;
        dir_adv  = 1'b0;
        wrap_adv = pos_q == 3'd7;
      end
      2'b01: begin
        pos_adv  = pos_q - 3'd1;
        dir_adv  = 1'b1;
        wrap_adv = pos_q == 3'd0;
      end
      2'b10: begin
        // a stale direction at either bound reverses immediately
        pos_adv  = going_up ? pos_q + 3'd1 : pos_q - 3'd1;
        dir_adv  = going_up ? pos_adv == 3'd7 : pos_adv != 3'd0;
        wrap_adv = ~going_up & (pos_adv == 3'd0);
      end
      default: moved = 1'b0;
    endcase
    wr      = load_i | (adv & moved);
    pos_d   = load_i ? load_val_i : adv ? pos_adv : pos_q;
    dir_d   = load_i ? 1'b0 : adv ? dir_adv : dir_q;
    wrap_d  = ~load_i & adv & wrap_adv;
    cnt_d   = (load_i | ~en_i | tick) ? '0 : cnt_q + 1'b1;
    blank_d = wr ? CNT_W'(BLANK_CYC) : blank_q != '0 ? blank_q - 1'b1 : '0;
    g_d     = ~(out_en_i & (blank_d == '0));
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pos_q   <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
      blank_q <= '0;
      step_q  <= 1'b0;
      g_q     <= 1'b1;
    end else begin
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      step_q  <= step_i;
      g_q     <= g_d;
    end
  end
  assign {c_o, b_o, a_o} = pos_q;
  assign g_o    = g_q;
  assign dir_o  = dir_q;
  assign wrap_o = wrap_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: directed checks of the decoder scan sequencer
module tb_decoder_scan_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, step = 1'b0, load = 1'b0, out_en = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [2:0] load_val = 3'd0;
  logic       a, b, c, g, dir, wrap;
  logic [5:0] obs, exp_v;
  int         errors = 0, checks = 0;
  int         pp_pos [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int         pp_dir [15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};

  decoder_scan_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .mode_i(mode), .step_i(step),
    .load_i(load), .load_val_i(load_val), .out_en_i(out_en),
    .a_o(a), .b_o(b), .c_o(c), .g_o(g), .dir_o(dir), .wrap_o(wrap)
  );

  always #5 clk = ~clk;
  assign obs = {c, b, a, dir, g, wrap};

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] v);
    load_val = v;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; out_en = 1'b1;
    cyc(3);
    checks++;
    if (obs !== 6'b000_0_1_0) begin errors++; $display("FAIL reset state: got %b expected %b", obs, 6'b000_0_1_0); end
    rst_n = 1'b1;
    cyc(1);
    checks++;
    if (obs !== 6'b000_0_0_0) begin errors++; $display("FAIL reset release G: got %b expected %b", obs, 6'b000_0_0_0); end
  endtask

  task automatic test_up;
    mode = 2'b00;
    do_load(3'd0);
    checks++;
    if (obs !== 6'b000_0_1_0) begin errors++; $display("FAIL up load: got %b expected %b", obs, 6'b000_0_1_0); end
    for (int k = 1; k <= 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        exp_v = {3'(k - 1), 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL up hold k=%0d j=%0d: got %b expected %b", k, j, obs, exp_v); end
      end
      cyc(1);
      exp_v = {3'(k), 1'b0, 1'b1, k == 8};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL up step k=%0d: got %b expected %b", k, obs, exp_v); end
    end
    cyc(1);
    checks++;
    if (obs !== 6'b000_0_0_0) begin errors++; $display("FAIL up wrap end: got %b expected %b", obs, 6'b000_0_0_0); end
  endtask

  task automatic test_pingpong;
    mode = 2'b10;
    do_load(3'd0);
    for (int k = 0; k < 15; k++) begin
      cyc(4);
      exp_v = {3'(pp_pos[k]), 1'(pp_dir[k]), 1'b1, k == 13};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pingpong step %0d: got %b expected %b", k, obs, exp_v); end
    end
  endtask

  task automatic test_down_load;
    mode = 2'b01;
    do_load(3'd2);
    checks++;
    if (obs !== 6'b010_0_1_0) begin errors++; $display("FAIL down load: got %b expected %b", obs, 6'b010_0_1_0); end
    cyc(4);
    checks++;
    if (obs !== 6'b001_1_1_0) begin errors++; $display("FAIL down 2->1: got %b expected %b", obs, 6'b001_1_1_0); end
    cyc(4);
    checks++;
    if (obs !== 6'b000_1_1_0) begin errors++; $display("FAIL down 1->0: got %b expected %b", obs, 6'b000_1_1_0); end
    cyc(4);
    checks++;
    if (obs !== 6'b111_1_1_1) begin errors++; $display("FAIL down 0->7: got %b expected %b", obs, 6'b111_1_1_1); end
    cyc(3);
    checks++;
    if (obs !== 6'b111_1_0_0) begin errors++; $display("FAIL down pre-tick: got %b expected %b", obs, 6'b111_1_0_0); end
    do_load(3'd5);
    checks++;
    if (obs !== 6'b101_0_1_0) begin errors++; $display("FAIL load on tick: got %b expected %b", obs, 6'b101_0_1_0); end
    cyc(3);
    checks++;
    if (obs !== 6'b101_0_0_0) begin errors++; $display("FAIL after load hold: got %b expected %b", obs, 6'b101_0_0_0); end
    cyc(1);
    checks++;
    if (obs !== 6'b100_1_1_0) begin errors++; $display("FAIL after load step: got %b expected %b", obs, 6'b100_1_1_0); end
  endtask

  task automatic test_step;
    en = 1'b0; mode = 2'b00;
    do_load(3'd3);
    for (int r = 0; r < 2; r++) begin
      step = 1'b1;
      cyc(5);
      exp_v = {3'(4 + r), 1'b0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL step burst %0d high: got %b expected %b", r, obs, exp_v); end
      step = 1'b0;
      cyc(5);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL step burst %0d low: got %b expected %b", r, obs, exp_v); end
    end
    en = 1'b1;
    do_load(3'd0);
    step = 1'b1; cyc(1);
    step = 1'b0; cyc(1);
    step = 1'b1; cyc(1);
    checks++;
    if (obs !== 6'b000_0_0_0) begin errors++; $display("FAIL step ignored with en: got %b expected %b", obs, 6'b000_0_0_0); end
    cyc(1);
    checks++;
    if (obs !== 6'b001_0_1_0) begin errors++; $display("FAIL auto step with en: got %b expected %b", obs, 6'b001_0_1_0); end
    step = 1'b0;
  endtask

  task automatic test_outen_reset;
    en = 1'b1; mode = 2'b01; out_en = 1'b0;
    do_load(3'd0);
    for (int e = 1; e <= 8; e++) begin
      cyc(1);
      exp_v = {(e < 4) ? 3'd0 : (e < 8) ? 3'd7 : 3'd6, e >= 4, 1'b1, e == 4};
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL outen off cycle %0d: got %b expected %b", e, obs, exp_v); end
    end
    out_en = 1'b1;
    cyc(1);
    checks++;
    if (obs !== 6'b110_1_0_0) begin errors++; $display("FAIL outen on: got %b expected %b", obs, 6'b110_1_0_0); end
    cyc(3);
    checks++;
    if (obs !== 6'b101_1_1_0) begin errors++; $display("FAIL blank before reset: got %b expected %b", obs, 6'b101_1_1_0); end
    rst_n = 1'b0;
    cyc(1);
    checks++;
    if (obs !== 6'b000_0_1_0) begin errors++; $display("FAIL reset mid-blank: got %b expected %b", obs, 6'b000_0_1_0); end
    rst_n = 1'b1;
    cyc(3);
    checks++;
    if (obs !== 6'b000_0_0_0) begin errors++; $display("FAIL post-reset hold: got %b expected %b", obs, 6'b000_0_0_0); end
    cyc(1);
    checks++;
    if (obs !== 6'b111_1_1_1) begin errors++; $display("FAIL post-reset step: got %b expected %b", obs, 6'b111_1_1_1); end
  endtask

  initial begin
    test_reset;
    test_up;
    test_pingpong;
    test_down_load;
    test_step;
    test_outen_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
